inference_frame_sequencer: RTL

- Hardware driver/collector for the batchnorm jet-tagging inference core: the core-facing side of its input_ready/output_ready frame handshake.
- Collects a serial stream of fixed-point features into a frame of INPUT_SIZE words.
- Per frame, resets the core, fires it, waits for output_ready plus a settle delay, captures and clamps the OUTPUT_SIZE softmax words, and streams them out with valid/ready and last.

---
 rtl/inference_frame_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/inference_frame_sequencer.sv
// ---------------------------------------------------------------------------
// inference_frame_sequencer
//
// Drives the frame handshake of the batchnorm jet-tagging inference core.
// Serial feature words are collected into a frame of INPUT_SIZE words. The
// core is then reset, fired and awaited. After a settle delay its
// OUTPUT_SIZE softmax words are captured and clamped. The results are then
// streamed out one word per handshake, with last marking the final word.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready     feature stream handshake, s_data = signed feature
//   core_reset          reset to the inference core
//   core_input_ready    one-cycle start pulse to the core
//   core_input_data     assembled feature frame (word i at [i*WIDTH +: WIDTH])
//   core_output_ready   core result valid (level)
//   core_output_data    core results (word i at [i*WIDTH +: WIDTH])
//   m_valid/m_ready     result stream handshake, m_data = result word,
//                       m_last = final word of a frame
//   busy                sequencer is not collecting features
//   timeout_err         sticky: a frame was aborted waiting for the core
//   frame_count         completed (non-aborted) frames, wraps at 2^32
// ---------------------------------------------------------------------------
module inference_frame_sequencer #(
    parameter int WIDTH         = 16,
    parameter int NFRAC         = 10,
    parameter int INPUT_SIZE    = 16,
    parameter int OUTPUT_SIZE   = 5,
    parameter int SETTLE_CYCLES = 10,
    parameter int TIMEOUT       = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [WIDTH-1:0]       s_data,
    output logic                          core_reset,
    output logic                          core_input_ready,
    output logic [INPUT_SIZE*WIDTH-1:0]   core_input_data,
    input  logic                          core_output_ready,
    input  logic [OUTPUT_SIZE*WIDTH-1:0]  core_output_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH-1:0]              m_data,
    output logic                          m_last,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [31:0]                   frame_count
);

    localparam int IDX_W   = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
    localparam int OIDX_W  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int CNT_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(INPUT_SIZE - 1);
    localparam logic [OIDX_W-1:0] OIDX_LAST   = OIDX_W'(OUTPUT_SIZE - 1);
    localparam logic [CNT_W-1:0]  RSTC_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0]  CLAMP_VAL   = WIDTH'(1) << NFRAC;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_RSTC,
        ST_GAP,
        ST_FIRE,
        ST_WAIT,
        ST_SETTLE,
        ST_DRAIN
    } state_t;

    state_t             state;
    logic               armed;      // low until the first edge after reset release
    logic [IDX_W-1:0]   idx;
    logic [OIDX_W-1:0]  oidx;
    logic [CNT_W-1:0]   cnt;        // shared by RSTC, WAIT and SETTLE
    logic               frame_to;   // current frame was aborted by timeout
    logic [WIDTH-1:0]   feature [INPUT_SIZE];
    logic [WIDTH-1:0]   result  [OUTPUT_SIZE];

    // Negative softmax words are not meaningful downstream; saturate them to 1.0.
    function automatic logic [WIDTH-1:0] clamp_word(input logic [WIDTH-1:0] w);
        return w[WIDTH-1] ? CLAMP_VAL : w;
    endfunction

    // Moore outputs: decoded from registered state only. armed keeps the
    // stream closed and the core in reset while reset is held.
    assign s_ready          = armed && (state == ST_LOAD);
    assign core_reset       = !armed || (state == ST_RSTC);
    assign core_input_ready = (state == ST_FIRE);
    assign m_valid          = (state == ST_DRAIN);
    assign m_data           = result[oidx];
    assign m_last           = (state == ST_DRAIN) && (oidx == OIDX_LAST);
    assign busy             = (state != ST_LOAD);

    // NOTE: every bit is assigned on every pass, so this block cannot infer a latch.
    always_comb begin
        core_input_data = '0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            core_input_data[i*WIDTH +: WIDTH] = feature[i];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_LOAD;
            armed       <= 1'b0;
            idx         <= '0;
            oidx        <= '0;
            cnt         <= '0;
            frame_to    <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= '0;
            // NOTE: the buffers are small and drive core_input_data directly,
            // so they are cleared with the rest of the state rather than left
            // as unreset storage.
            for (int i = 0; i < INPUT_SIZE; i++) begin
                feature[i] <= '0;
            end
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                result[i] <= '0;
            end
        end else begin
            armed <= 1'b1;
            case (state)
                ST_LOAD: begin
                    if (s_valid && s_ready) begin
                        feature[idx] <= s_data;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            cnt   <= '0;
                            state <= ST_RSTC;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                // Core held in reset for two cycles.
                ST_RSTC: begin
                    if (cnt == RSTC_LAST) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    state <= ST_FIRE;
                end

                ST_FIRE: begin
                    cnt      <= '0;
                    frame_to <= 1'b0;
                    state    <= ST_WAIT;
                end

                // A response in the same cycle as the timeout wins.
                ST_WAIT: begin
                    if (core_output_ready) begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end else if (cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        frame_to    <= 1'b1;
                        for (int i = 0; i < OUTPUT_SIZE; i++) begin
                            result[i] <= '0;
                        end
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Capture at the end of the settle window regardless of
                // whether core_output_ready is still asserted.
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        for (int i = 0; i < OUTPUT_SIZE; i++) begin
                            result[i] <= clamp_word(core_output_data[i*WIDTH +: WIDTH]);
                        end
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (m_ready) begin
                        if (oidx == OIDX_LAST) begin
                            oidx  <= '0;
                            state <= ST_LOAD;
                            if (!frame_to) begin
                                frame_count <= frame_count + 1'b1;
                            end
                        end else begin
                            oidx <= oidx + 1'b1;
                        end
                    end
                end

                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
